system: RTL and testbench
=========================

SYSTEM -- requirements
Module: system

Interface
REQ-001 The block SHALL use one clock, avr_clk; reset is avr_reset, synchronous and active-high.
REQ-002 avr_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 avr_reset  input  1  synchronous active-high reset.
REQ-004 avr_si  input  1  serial address bit, shifted MSB-first.
REQ-005 avr_sreg_en  input  1  0 = shift address in, 1 = hold address and enable the bus.
REQ-006 avr_oe  input  1  active-low read request (SRAM to AVR).
REQ-007 avr_we  input  1  active-low write request (AVR to SRAM).
REQ-008 avr_ce  input  1  reserved; ignored.
REQ-009 avr_ctrl  input  3  reserved; ignored.
REQ-010 avr_data  inout  8  AVR data bus; driven only in READ, else hi-Z.
REQ-011 sram_addr  output  21  SRAM address, equal to the shift register contents at all times.
REQ-012 sram_data  inout  8  SRAM data bus; driven only in WRITE, else hi-Z.
REQ-013 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM controls.

Function
REQ-014 Address shift register: 21 bits.
- While avr_sreg_en=0, each edge loads {sreg[19:0], avr_si}.
- While avr_sreg_en=1, the register holds.
REQ-015 Bus FSM states: IDLE=2'b00, READ=2'b01, WRITE=2'b10; the 2'b11 encoding SHALL recover to IDLE on the next edge.
REQ-016 The FSM request is evaluated each edge.
- READ request = avr_sreg_en=1, avr_oe=0, avr_we=1.
- WRITE request = avr_sreg_en=1, avr_we=0, avr_oe=1.
- Anything else, including avr_oe=avr_we=0, is no request.
REQ-017 FSM transitions:
- IDLE goes to READ or WRITE on the matching request, else stays in IDLE.
- READ stays in READ while the READ request holds, else goes to IDLE.
- WRITE stays in WRITE while the WRITE request holds, else goes to IDLE.
- READ to WRITE (and the reverse) always passes through one IDLE cycle, for bus turnaround.
REQ-018 An 8-bit data buffer SHALL be updated as follows:
- In READ, it captures sram_data each edge.
- In WRITE, it captures avr_data each edge.
- In IDLE, it holds.
REQ-019 In READ:
- sram_ce_n=0, sram_oe_n=0, sram_we_n=1.
- avr_data is driven with the buffer, so AVR sees SRAM data one cycle after it is sampled.
REQ-020 In WRITE:
- sram_ce_n=0, sram_oe_n=1, sram_we_n=0.
- sram_data is driven with the buffer, one cycle of latency from avr_data.
REQ-021 In IDLE:
- sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
- Both data buses are hi-Z.
REQ-022 The two data buses SHALL never be driven by the block in the same cycle.
REQ-023 All control outputs SHALL be registered, or decoded from the state register only; they SHALL have no combinational path from avr_oe or avr_we.
REQ-024 If avr_sreg_en falls to 0 during READ or WRITE, the FSM SHALL return to IDLE on the next edge; shifting resumes on that same edge.

Reset
REQ-025 When avr_reset=1 at an edge:
- Shift register = 0 and sram_addr = 21'h000000.
- FSM = IDLE and buffer = 8'h00.
- sram_ce_n/oe_n/we_n = 1 and both buses hi-Z.
REQ-026 Reset SHALL take priority over shifting and over FSM activity, including when it is asserted mid-READ or mid-WRITE.

Verification
REQ-027 Reset, then avr_sreg_en=0 and shift avr_si = 1,1,0,0,1,1,0,0,1,1,0,0,1,1,1,1 over 16 edges -> sram_addr = 21'h00CCCF; the value holds after avr_sreg_en=1.
REQ-028 avr_sreg_en=1, avr_oe=0, avr_we=1, SRAM drives 8'hAA -> state READ, sram_oe_n=0, sram_ce_n=0; avr_data = 8'hAA one edge after sampling.
REQ-029 Continuing REQ-028, SRAM changes to 8'hBB -> avr_data = 8'hBB after one edge, with no return to IDLE.
REQ-030 Switch to avr_oe=1, avr_we=0, AVR drives 8'hEE -> one IDLE cycle with both buses hi-Z, then WRITE; sram_we_n=0, sram_data = 8'hEE after one edge, avr_data not driven.
REQ-031 Switch back to avr_oe=0, avr_we=1, SRAM drives 8'h22 -> IDLE for one cycle, then READ; avr_data = 8'h22.
REQ-032 Drive avr_oe=avr_we=0, or avr_sreg_en=0, or assert avr_reset mid-WRITE -> IDLE, all SRAM controls high, buses hi-Z on the next edge.

Source files
------------

// File: rtl/system.sv
// AVR-to-SRAM bridge: serially loaded 21-bit address plus a turnaround-safe read/write bus FSM.
// Every control output and bus-drive enable is registered from the next state.
module system (
  input  logic        avr_clk,
  input  logic        avr_reset,
  input  logic        avr_si,
  input  logic        avr_sreg_en,
  input  logic        avr_oe,
  input  logic        avr_we,
  input  logic        avr_ce,
  input  logic [2:0]  avr_ctrl,
  inout  wire  [7:0]  avr_data,
  output logic [20:0] sram_addr,
  inout  wire  [7:0]  sram_data,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [20:0] sreg;
  logic [7:0]  buffer;
  logic        drive_avr;
  logic        drive_sram;
  logic        read_req;
  logic        write_req;
  logic        unused_ok;

  assign unused_ok = ^{avr_ce, avr_ctrl};

  assign read_req  = avr_sreg_en & ~avr_oe &  avr_we;
  assign write_req = avr_sreg_en &  avr_oe & ~avr_we;

  // A direct READ<->WRITE hop is impossible: losing the current request always lands in IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (read_req)       state_nxt = READ;
        else if (write_req) state_nxt = WRITE;
        else                state_nxt = IDLE;
      end
      READ:    state_nxt = read_req  ? READ  : IDLE;
      WRITE:   state_nxt = write_req ? WRITE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      state      <= IDLE;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      drive_avr  <= 1'b0;
      drive_sram <= 1'b0;
    end else begin
      state      <= state_nxt;
      sram_ce_n  <= (state_nxt == IDLE);
      sram_oe_n  <= (state_nxt != READ);
      sram_we_n  <= (state_nxt != WRITE);
      drive_avr  <= (state_nxt == READ);
      drive_sram <= (state_nxt == WRITE);
    end
  end

  always_ff @(posedge avr_clk) begin
    if (avr_reset)         sreg <= '0;
    else if (!avr_sreg_en) sreg <= {sreg[19:0], avr_si};
  end

  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      buffer <= '0;
    end else begin
      case (state)
        READ:    buffer <= sram_data;
        WRITE:   buffer <= avr_data;
        default: buffer <= buffer;
      endcase
    end
  end

  assign sram_addr = sreg;
  assign avr_data  = drive_avr  ? buffer : 8'bz;
  assign sram_data = drive_sram ? buffer : 8'bz;

endmodule

// File: tb/tb_system.sv
// Directed bench for the AVR/SRAM bridge: address shifting, read/write turnaround, abort and reset.
// Released buses are probed by driving a known pattern from the bench side and reading it back.
module tb_system;

  logic        clk;
  logic        rst;
  logic        si;
  logic        sreg_en;
  logic        oe;
  logic        we;
  logic        ce;
  logic [2:0]  ctrl;
  wire  [7:0]  avr_data;
  wire  [7:0]  sram_data;
  logic [20:0] sram_addr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  logic        avr_drv;
  logic [7:0]  avr_val;
  logic        sram_drv;
  logic [7:0]  sram_val;

  int checks = 0;
  int errors = 0;

  assign avr_data  = avr_drv  ? avr_val  : 8'bz;
  assign sram_data = sram_drv ? sram_val : 8'bz;

  system dut (
    .avr_clk     (clk),
    .avr_reset   (rst),
    .avr_si      (si),
    .avr_sreg_en (sreg_en),
    .avr_oe      (oe),
    .avr_we      (we),
    .avr_ce      (ce),
    .avr_ctrl    (ctrl),
    .avr_data    (avr_data),
    .sram_addr   (sram_addr),
    .sram_data   (sram_data),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic        si;
    logic        oe;
    logic        we;
    logic        avr_drv;
    logic [7:0]  avr_val;
    logic        sram_drv;
    logic [7:0]  sram_val;
    logic [20:0] exp_addr;
    logic [2:0]  exp_ctl;   // {ce_n, oe_n, we_n}
    logic        chk_avr;
    logic [7:0]  exp_avr;
    logic        chk_sram;
    logic [7:0]  exp_sram;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [20:0] e_addr, input logic [2:0] e_ctl,
                               input logic c_avr, input logic [7:0] e_avr,
                               input logic c_sram, input logic [7:0] e_sram);
    check({name, ".addr"}, {11'd0, sram_addr}, {11'd0, e_addr});
    check({name, ".ctl"}, {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, {29'd0, e_ctl});
    if (c_avr)  check({name, ".avr_data"},  {24'd0, avr_data},  {24'd0, e_avr});
    if (c_sram) check({name, ".sram_data"}, {24'd0, sram_data}, {24'd0, e_sram});
  endtask

  function automatic vec_t mk(string name, logic r, logic en, logic s, logic o, logic w,
                              logic ad, logic [7:0] av, logic sd, logic [7:0] sv,
                              logic [20:0] ea, logic [2:0] ec,
                              logic ca, logic [7:0] ea8, logic cs, logic [7:0] es8);
    vec_t v;
    v.name = name; v.rst = r; v.en = en; v.si = s; v.oe = o; v.we = w;
    v.avr_drv = ad; v.avr_val = av; v.sram_drv = sd; v.sram_val = sv;
    v.exp_addr = ea; v.exp_ctl = ec;
    v.chk_avr = ca; v.exp_avr = ea8; v.chk_sram = cs; v.exp_sram = es8;
    return v;
  endfunction

  logic [15:0] pattern;
  logic [20:0] model_addr;

  initial begin
    ce = 1'b1; ctrl = 3'b000;
    si = 1'b0; sreg_en = 1'b0; oe = 1'b1; we = 1'b1;
    avr_drv = 1'b1; avr_val = 8'h5A; sram_drv = 1'b1; sram_val = 8'hA5;
    rst = 1'b1;

    // Reset: address cleared, controls high, both buses released.
    @(posedge clk); #1;
    check_outputs("reset", 21'h0, 3'b111, 1'b1, 8'h5A, 1'b1, 8'hA5);
    rst = 1'b0;

    // Shift 16 bits MSB-first while idle.
    pattern = 16'b1100_1100_1100_1111;
    model_addr = '0;
    for (int i = 15; i >= 0; i--) begin
      si = pattern[i];
      model_addr = {model_addr[19:0], pattern[i]};
      @(posedge clk); #1;
      check_outputs($sformatf("shift%0d", 15 - i), model_addr, 3'b111, 1'b1, 8'h5A, 1'b1, 8'hA5);
    end
    check("shift_final", {11'd0, sram_addr}, 32'h0000CCCF);

    //          name          rst en si oe we  avr      sram       addr       ctl     avr chk   sram chk
    vecs.push_back(mk("hold",     0, 1, 0, 1, 1, 1, 8'h5A, 1, 8'hA5, 21'h0CCCF, 3'b111, 1, 8'h5A, 1, 8'hA5));
    vecs.push_back(mk("rd_enter", 0, 1, 0, 0, 1, 0, 8'h00, 1, 8'hAA, 21'h0CCCF, 3'b001, 1, 8'h00, 1, 8'hAA));
    vecs.push_back(mk("rd_AA",    0, 1, 0, 0, 1, 0, 8'h00, 1, 8'hAA, 21'h0CCCF, 3'b001, 1, 8'hAA, 1, 8'hAA));
    vecs.push_back(mk("rd_BB",    0, 1, 0, 0, 1, 0, 8'h00, 1, 8'hBB, 21'h0CCCF, 3'b001, 1, 8'hBB, 1, 8'hBB));
    vecs.push_back(mk("rd2wr_idl",0, 1, 0, 1, 0, 0, 8'h00, 1, 8'hA5, 21'h0CCCF, 3'b111, 0, 8'h00, 1, 8'hA5));
    vecs.push_back(mk("wr_enter", 0, 1, 0, 1, 0, 1, 8'hEE, 0, 8'h00, 21'h0CCCF, 3'b010, 1, 8'hEE, 1, 8'hA5));
    vecs.push_back(mk("wr_EE",    0, 1, 0, 1, 0, 1, 8'hEE, 0, 8'h00, 21'h0CCCF, 3'b010, 1, 8'hEE, 1, 8'hEE));
    vecs.push_back(mk("wr2rd_idl",0, 1, 0, 0, 1, 1, 8'h3C, 0, 8'h00, 21'h0CCCF, 3'b111, 1, 8'h3C, 0, 8'h00));
    vecs.push_back(mk("rd2_enter",0, 1, 0, 0, 1, 0, 8'h00, 1, 8'h22, 21'h0CCCF, 3'b001, 1, 8'h3C, 1, 8'h22));
    vecs.push_back(mk("rd_22",    0, 1, 0, 0, 1, 0, 8'h00, 1, 8'h22, 21'h0CCCF, 3'b001, 1, 8'h22, 1, 8'h22));
    vecs.push_back(mk("rd_exit",  0, 1, 0, 1, 0, 0, 8'h00, 1, 8'h22, 21'h0CCCF, 3'b111, 0, 8'h00, 1, 8'h22));
    vecs.push_back(mk("wr2_enter",0, 1, 0, 1, 0, 1, 8'h77, 0, 8'h00, 21'h0CCCF, 3'b010, 1, 8'h77, 1, 8'h22));
    vecs.push_back(mk("both_low", 0, 1, 0, 0, 0, 1, 8'h77, 0, 8'h00, 21'h0CCCF, 3'b111, 1, 8'h77, 0, 8'h00));
    vecs.push_back(mk("wr3_enter",0, 1, 0, 1, 0, 1, 8'h66, 0, 8'h00, 21'h0CCCF, 3'b010, 1, 8'h66, 1, 8'h77));
    vecs.push_back(mk("en_drop",  0, 0, 1, 1, 0, 1, 8'h66, 0, 8'h00, 21'h1999F, 3'b111, 1, 8'h66, 0, 8'h00));
    vecs.push_back(mk("wr4_enter",0, 1, 0, 1, 0, 1, 8'h55, 0, 8'h00, 21'h1999F, 3'b010, 1, 8'h55, 1, 8'h66));
    vecs.push_back(mk("wr_reset", 1, 1, 0, 1, 0, 1, 8'h55, 0, 8'h00, 21'h00000, 3'b111, 1, 8'h55, 0, 8'h00));
    vecs.push_back(mk("wr_after", 0, 1, 0, 1, 0, 1, 8'h55, 0, 8'h00, 21'h00000, 3'b010, 1, 8'h55, 1, 8'h00));
    vecs.push_back(mk("wr_rst2",  1, 1, 0, 1, 0, 1, 8'h55, 0, 8'h00, 21'h00000, 3'b111, 1, 8'h55, 0, 8'h00));
    vecs.push_back(mk("idle_end", 0, 1, 0, 1, 1, 1, 8'h5A, 1, 8'hA5, 21'h00000, 3'b111, 1, 8'h5A, 1, 8'hA5));

    foreach (vecs[k]) begin
      rst = vecs[k].rst; sreg_en = vecs[k].en; si = vecs[k].si;
      oe = vecs[k].oe; we = vecs[k].we;
      avr_drv = vecs[k].avr_drv; avr_val = vecs[k].avr_val;
      sram_drv = vecs[k].sram_drv; sram_val = vecs[k].sram_val;
      @(posedge clk); #1;
      check_outputs(vecs[k].name, vecs[k].exp_addr, vecs[k].exp_ctl,
                    vecs[k].chk_avr, vecs[k].exp_avr, vecs[k].chk_sram, vecs[k].exp_sram);
    end

    // Reset asserted mid-READ while the address is shifting back in.
    rst = 1'b0; sreg_en = 1'b0; si = 1'b1; oe = 1'b1; we = 1'b1;
    avr_drv = 1'b1; avr_val = 8'h5A; sram_drv = 1'b1; sram_val = 8'hA5;
    @(posedge clk); #1;
    check_outputs("shift_one", 21'h00001, 3'b111, 1'b1, 8'h5A, 1'b1, 8'hA5);
    sreg_en = 1'b1; oe = 1'b0; avr_drv = 1'b0; sram_val = 8'hC3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_outputs("rd_C3", 21'h00001, 3'b001, 1'b1, 8'hC3, 1'b1, 8'hC3);
    rst = 1'b1; sreg_en = 1'b0;
    @(posedge clk); #1;
    avr_drv = 1'b1; avr_val = 8'h5A;
    #1;
    check_outputs("rd_reset", 21'h00000, 3'b111, 1'b1, 8'h5A, 1'b1, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
